// File: rtl/mem_controller_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and packed-bus slice helper.
package mem_controller_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  // Low bit of element 'index' in a vector of equally sized packed fields.
  function automatic int slice_lo(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/mem_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] rr_ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  localparam logic [IW:0] NUM = (IW + 1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    sum         = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (sum >= NUM) begin
        sum = sum - NUM;
      end
      idx = sum[IW-1:0];
      if (request[idx]) begin
        grant_valid = 1'b1;
        grant_index = idx;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Serialises per-core read/write requests onto one data-memory channel with round-robin fairness.
// Registered outputs only; one memory transaction outstanding, ready held until the core drops valid.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CONSUMERS - 1);

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic          arb_valid;
  logic [IW-1:0] arb_index;

  rr_arbiter #(
    .N  (NUM_CONSUMERS),
    .IW (IW)
  ) u_arb (
    .request     (consumer_read_valid | consumer_write_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (arb_valid),
    .grant_index (arb_index)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      grant                <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant <= arb_index;
            // A core holding both requests gets its read first.
            if (consumer_read_valid[arb_index]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[slice_lo(int'(arb_index), ADDR_BITS) +: ADDR_BITS];
              state            <= READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[slice_lo(int'(arb_index), ADDR_BITS) +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[slice_lo(int'(arb_index), DATA_BITS) +: DATA_BITS];
              state             <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            consumer_read_data[slice_lo(int'(grant), DATA_BITS) +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant] <= 1'b1;
            mem_read_valid             <= 1'b0;
            state                      <= READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            consumer_write_ready[grant] <= 1'b1;
            mem_write_valid             <= 1'b0;
            state                       <= WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[grant]) begin
            consumer_read_ready[grant] <= 1'b0;
            rr_ptr                     <= (grant == LAST) ? '0 : grant + 1'b1;
            state                      <= IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[grant]) begin
            consumer_write_ready[grant] <= 1'b0;
            rr_ptr                      <= (grant == LAST) ? '0 : grant + 1'b1;
            state                       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Randomised bench for mem_controller: behavioural cores and memory, round-robin reference model.
module tb_mem_controller;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    int         core;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  consumer_read_valid, consumer_read_ready;
  logic [N-1:0]  consumer_write_valid, consumer_write_ready;
  logic [N*AW-1:0] consumer_read_address, consumer_write_address;
  logic [N*DW-1:0] consumer_read_data, consumer_write_data;
  logic          mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data, mem_write_data;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  int   mem_delay = -1;
  int   rd_wait = 0, wr_wait = 0;
  bit   rd_armed = 0, wr_armed = 0;
  int   rd_hold [N];
  int   wr_hold [N];
  int   m_ptr = 0;
  txn_t obs_q [$];
  txn_t mem_q [$];
  txn_t exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input int c, input bit w, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.core = c; t.wr = w; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic int pick_delay();
    return (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
  endfunction

  // Memory: ready raised after a chosen number of waiting cycles, held for exactly one edge.
  task automatic mem_step();
    if (mem_read_ready) mem_read_ready = 1'b0;
    else if (mem_read_valid) begin
      if (!rd_armed) begin rd_wait = pick_delay(); rd_armed = 1; end
      if (rd_wait == 0) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem_arr[mem_read_address];
        mem_q.push_back(mk(-1, 1'b0, mem_read_address, mem_read_data));
        rd_armed = 0;
      end else rd_wait--;
    end
    if (mem_write_ready) mem_write_ready = 1'b0;
    else if (mem_write_valid) begin
      if (!wr_armed) begin wr_wait = pick_delay(); wr_armed = 1; end
      if (wr_wait == 0) begin
        mem_write_ready = 1'b1;
        mem_arr[mem_write_address] = mem_write_data;
        mem_q.push_back(mk(-1, 1'b1, mem_write_address, mem_write_data));
        wr_armed = 0;
      end else wr_wait--;
    end
  endtask

  // Cores: keep valid up while ready is seen for a few extra cycles, then drop it.
  task automatic core_step();
    for (int i = 0; i < N; i++) begin
      if (consumer_read_valid[i] && consumer_read_ready[i]) begin
        if (rd_hold[i] > 0) rd_hold[i]--;
        else begin
          obs_q.push_back(mk(i, 1'b0, consumer_read_address[i*AW +: AW], consumer_read_data[i*DW +: DW]));
          consumer_read_valid[i] = 1'b0;
        end
      end
      if (consumer_write_valid[i] && consumer_write_ready[i]) begin
        if (wr_hold[i] > 0) wr_hold[i]--;
        else begin
          obs_q.push_back(mk(i, 1'b1, consumer_write_address[i*AW +: AW], consumer_write_data[i*DW +: DW]));
          consumer_write_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("ready_onehot", ($countones({consumer_read_ready, consumer_write_ready}) <= 1), 1);
    mem_step();
    core_step();
  endtask

  task automatic drain(input string tag);
    int budget = 400;
    while ((consumer_read_valid | consumer_write_valid) != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq({tag, "_done"}, ((consumer_read_valid | consumer_write_valid) == 0), 1);
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    tick();
    tick();
  endtask

  task automatic clear_logs();
    obs_q.delete(); mem_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    consumer_read_valid = '0; consumer_write_valid = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    rd_armed = 0; wr_armed = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mem_vld", {mem_read_valid, mem_write_valid}, 0);
    check_eq("rst_rdy", {consumer_read_ready, consumer_write_ready}, 0);
    check_eq("rst_rd_data", consumer_read_data, 0);
    check_eq("rst_mem_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
    reset = 1'b0;
    m_ptr = 0;
    clear_logs();
  endtask

  // Reference: with all requests present from the start, grants follow round-robin order
  // from the pointer, a core's read before its write, and the pointer moves past each grantee.
  task automatic run_burst(input logic [N-1:0] rd, input logic [N-1:0] wr, input string tag);
    logic [N-1:0] prd = rd;
    logic [N-1:0] pwr = wr;
    clear_logs();
    while ((prd | pwr) != 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (prd[c] || pwr[c]) begin
          if (prd[c]) begin
            logic [7:0] a = consumer_read_address[c*AW +: AW];
            exp_q.push_back(mk(c, 1'b0, a, ref_mem[a]));
            prd[c] = 1'b0;
          end else begin
            logic [7:0] a = consumer_write_address[c*AW +: AW];
            logic [7:0] d = consumer_write_data[c*DW +: DW];
            exp_q.push_back(mk(c, 1'b1, a, d));
            ref_mem[a] = d;
            pwr[c] = 1'b0;
          end
          m_ptr = (c + 1) % N;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      rd_hold[i] = $urandom_range(0, 2);
      wr_hold[i] = $urandom_range(0, 2);
    end
    consumer_read_valid  = rd;
    consumer_write_valid = wr;
    drain(tag);
    check_eq({tag, "_ncore"}, obs_q.size(), exp_q.size());
    check_eq({tag, "_nmem"}, mem_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j < obs_q.size()) begin
        check_eq($sformatf("%s[%0d].core", tag, j), obs_q[j].core, exp_q[j].core);
        check_eq($sformatf("%s[%0d].kind", tag, j), obs_q[j].wr, exp_q[j].wr);
        if (!exp_q[j].wr)
          check_eq($sformatf("%s[%0d].rdata", tag, j), obs_q[j].data, exp_q[j].data);
      end
      if (j < mem_q.size()) begin
        check_eq($sformatf("%s[%0d].mkind", tag, j), mem_q[j].wr, exp_q[j].wr);
        check_eq($sformatf("%s[%0d].maddr", tag, j), mem_q[j].addr, exp_q[j].addr);
        check_eq($sformatf("%s[%0d].mdata", tag, j), mem_q[j].data, exp_q[j].data);
      end
    end
    clear_logs();
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    consumer_read_valid = '0; consumer_write_valid = '0;
    consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < N; i++) begin rd_hold[i] = 0; wr_hold[i] = 0; end
    do_reset();

    // Memory ready outside the waiting states must not start or complete anything.
    mem_read_ready = 1'b1; mem_write_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_ignore_rdy", {mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}, 0);
    end
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;

    // Minimum read latency with zero-wait memory, then release-to-next-grant timing.
    mem_delay = 0;
    consumer_read_address[0 +: AW] = 8'h21;
    consumer_read_valid = 4'b0001;
    @(negedge clk);
    check_eq("lat_mem_vld", mem_read_valid, 1);
    check_eq("lat_mem_addr", mem_read_address, 8'h21);
    check_eq("lat_no_rdy_yet", consumer_read_ready, 0);
    mem_step();
    @(negedge clk);
    check_eq("lat_core_rdy", consumer_read_ready, 4'b0001);
    check_eq("lat_core_data", consumer_read_data[0 +: DW], ref_mem[8'h21]);
    mem_step();
    consumer_read_address[AW +: AW] = 8'h22;
    consumer_read_valid = 4'b0010;
    @(negedge clk);
    check_eq("rel_rdy_low", consumer_read_ready, 0);
    check_eq("rel_no_grant_yet", mem_read_valid, 0);
    @(negedge clk);
    check_eq("rel_next_grant", mem_read_valid, 1);
    check_eq("rel_next_addr", mem_read_address, 8'h22);
    drain("rel");
    check_eq("rel_slot1", consumer_read_data[DW +: DW], ref_mem[8'h22]);
    m_ptr = 2;
    clear_logs();

    // Single read: core 2, address 0x15, memory answers 0x5A after waiting.
    mem_delay = 3;
    mem_arr[8'h15] = 8'h5A; ref_mem[8'h15] = 8'h5A;
    consumer_read_address[2*AW +: AW] = 8'h15;
    run_burst(4'b0100, 4'b0000, "rd_single");
    check_eq("rd_single_slot2", consumer_read_data[2*DW +: DW], 8'h5A);
    check_eq("rd_single_maddr", mem_read_address, 8'h15);

    // Single write: core 1 writes 0xC3 to 0x40.
    mem_delay = -1;
    consumer_write_address[AW +: AW] = 8'h40;
    consumer_write_data[DW +: DW] = 8'hC3;
    run_burst(4'b0000, 4'b0010, "wr_single");
    check_eq("wr_single_mem", mem_arr[8'h40], 8'hC3);
    check_eq("wr_single_bus", {mem_write_address, mem_write_data}, 16'h40C3);

    // Contention straight after reset: order 0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) consumer_read_address[i*AW +: AW] = 8'(8'h80 + i);
    run_burst(4'b1111, 4'b0000, "contend");

    // Fairness wrap: core 3 alone, then cores 0 and 3 together.
    run_burst(4'b1000, 4'b0000, "wrap_a");
    run_burst(4'b1001, 4'b0000, "wrap_b");

    // Same core read and write to one address: read sees the old value.
    consumer_read_address[0 +: AW] = 8'h30;
    consumer_write_address[0 +: AW] = 8'h30;
    consumer_write_data[0 +: DW] = 8'h77;
    run_burst(4'b0001, 4'b0001, "rw_same");

    // Move the pointer to 3, then abandon a read in flight via reset.
    run_burst(4'b0100, 4'b0000, "pre_rst");
    consumer_read_address[AW +: AW] = 8'h05;
    consumer_read_valid = 4'b0010;
    for (int k = 0; k < 10 && !mem_read_valid; k++) @(negedge clk);
    check_eq("midrst_waiting", mem_read_valid, 1);
    reset = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data = 8'hEE;
    @(negedge clk);
    check_eq("midrst_mem_vld", {mem_read_valid, mem_write_valid}, 0);
    check_eq("midrst_rdy", {consumer_read_ready, consumer_write_ready}, 0);
    check_eq("midrst_no_capture", consumer_read_data[DW +: DW], 0);
    reset = 1'b0;
    mem_read_ready = 1'b0;
    consumer_read_valid = '0;
    rd_armed = 0; wr_armed = 0;
    m_ptr = 0;
    @(negedge clk);
    consumer_read_address[3*AW +: AW] = 8'h06;
    run_burst(4'b1010, 4'b0000, "post_rst");

    // Random bursts over a small address range to force read/write collisions.
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++) begin
        consumer_read_address[i*AW +: AW]  = 8'($urandom_range(0, 15));
        consumer_write_address[i*AW +: AW] = 8'($urandom_range(0, 15));
        consumer_write_data[i*DW +: DW]    = 8'($urandom);
      end
      run_burst(4'($urandom), 4'($urandom), $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
